// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Package : video_pkg
// Brief   : Shared constants and types for the tile renderer fetch path.
// Rev     : 1.0  initial release
// ============================================================================
package video_pkg;

    localparam int MAP_W      = 32;
    localparam int MAP_AW     = 10;
    localparam int TILE_AW    = 11;
    localparam int FINE_W     = 3;
    localparam int TILE_IDX_W = 8;
    localparam int ROW_W      = 4;
    localparam int COL_W      = $clog2(MAP_W);
    // map address = {row, column}; the row field is wider than line_i[6:3]
    localparam int MAP_ROW_W  = MAP_AW - COL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAP  = 2'd1,
        TILE = 2'd2,
        DATA = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/tile_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module  : tile_fetch_seq
// Brief   : Per-scanline map/tile BRAM fetch sequencer feeding the pixel shifter.
// Rev     : 1.0  initial release
// ============================================================================
module tile_fetch_seq
    import video_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 line_start_i,
    input  logic [7:0]           line_i,
    input  logic [4:0]           col_base_i,
    output logic [MAP_AW-1:0]    map_addr_o,
    input  logic [7:0]           map_data_i,
    output logic [TILE_AW-1:0]   tile_addr_o,
    input  logic [15:0]          tile_data_i,
    output logic                 px_valid_o,
    input  logic                 px_ready_i,
    output logic [15:0]          px_data_o,
    output logic [COL_W-1:0]     px_col_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overrun_o
);

    localparam logic [COL_W-1:0] c_last_col = COL_W'(MAP_W - 1);

    fetch_state_t            r_state;
    fetch_state_t            w_state_nxt;
    logic [ROW_W-1:0]        r_row;
    logic [FINE_W-1:0]       r_fine;
    logic [COL_W-1:0]        r_col_base;
    logic [COL_W-1:0]        r_col;
    logic [TILE_IDX_W-1:0]   r_tile_idx;
    logic                    r_px_valid;
    logic [15:0]             r_px_data;
    logic [COL_W-1:0]        r_px_col;
    logic                    r_overrun;

    logic                    w_load;
    logic                    w_last;
    logic [COL_W-1:0]        w_map_col;
    logic                    w_unused;

    assign w_unused  = line_i[7];
    assign w_map_col = r_col_base + r_col;
    assign w_last    = (r_col == c_last_col);
    // the output slot is free when empty or being consumed this cycle
    assign w_load    = (r_state == DATA) && (!r_px_valid || px_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (line_start_i) w_state_nxt = MAP;
            MAP:  w_state_nxt = TILE;
            TILE: w_state_nxt = DATA;
            DATA: if (w_load) w_state_nxt = w_last ? IDLE : MAP;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_row      <= '0;
            r_fine     <= '0;
            r_col_base <= '0;
            r_col      <= '0;
            r_tile_idx <= '0;
            r_px_valid <= 1'b0;
            r_px_data  <= '0;
            r_px_col   <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= line_start_i && (r_state != IDLE);
            if ((r_state == IDLE) && line_start_i) begin
                r_row      <= line_i[6:3];
                r_fine     <= line_i[2:0];
                r_col_base <= col_base_i[COL_W-1:0];
                r_col      <= '0;
            end
            if (r_state == TILE) begin
                r_tile_idx <= map_data_i;
            end
            if (w_load) begin
                r_px_data  <= tile_data_i;
                r_px_col   <= r_col;
                r_px_valid <= 1'b1;
                if (!w_last) begin
                    r_col <= r_col + COL_W'(1);
                end
            end else if (r_px_valid && px_ready_i) begin
                r_px_valid <= 1'b0;
            end
        end
    end

    // tile address is taken straight from map data in TILE, then held from the capture
    always_comb begin
        map_addr_o  = '0;
        tile_addr_o = '0;
        if (r_state != IDLE) begin
            map_addr_o  = {MAP_ROW_W'(r_row), w_map_col};
            tile_addr_o = {r_tile_idx, r_fine};
        end
        if (r_state == TILE) begin
            tile_addr_o = {map_data_i, r_fine};
        end
    end

    assign px_valid_o = r_px_valid;
    assign px_data_o  = r_px_data;
    assign px_col_o   = r_px_col;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = w_load && w_last;
    assign overrun_o  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_tile_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_tile_fetch_seq
// Brief   : Self-checking bench for tile_fetch_seq against a word-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_tile_fetch_seq;
    import video_pkg::*;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                line_start_i;
    logic [7:0]          line_i;
    logic [4:0]          col_base_i;
    logic [MAP_AW-1:0]   map_addr_o;
    logic [7:0]          map_data_i;
    logic [TILE_AW-1:0]  tile_addr_o;
    logic [15:0]         tile_data_i;
    logic                px_valid_o;
    logic                px_ready_i;
    logic [15:0]         px_data_o;
    logic [COL_W-1:0]    px_col_o;
    logic                busy_o;
    logic                done_o;
    logic                overrun_o;

    always #5 clk_i = ~clk_i;

    tile_fetch_seq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .line_start_i (line_start_i),
        .line_i       (line_i),
        .col_base_i   (col_base_i),
        .map_addr_o   (map_addr_o),
        .map_data_i   (map_data_i),
        .tile_addr_o  (tile_addr_o),
        .tile_data_i  (tile_data_i),
        .px_valid_o   (px_valid_o),
        .px_ready_i   (px_ready_i),
        .px_data_o    (px_data_o),
        .px_col_o     (px_col_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overrun_o    (overrun_o)
    );

    logic [7:0]  map_mem  [0:1023];
    logic [15:0] tile_mem [0:2047];

    always @(posedge clk_i) begin
        map_data_i  <= map_mem[map_addr_o];
        tile_data_i <= tile_mem[tile_addr_o];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ovr_seen = 0;

    always @(posedge clk_i) cyc++;
    always @(negedge clk_i) if (rst_ni && overrun_o) ovr_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int map_index(int row, int cb, int k);
        return row * MAP_W + ((cb + k) % MAP_W);
    endfunction

    function automatic int tile_index(int row, int fine, int cb, int k);
        return int'(map_mem[map_index(row, cb, k)]) * 8 + fine;
    endfunction

    function automatic logic [15:0] word_of(int row, int fine, int cb, int k);
        return tile_mem[tile_index(row, fine, cb, k)];
    endfunction

    // Word-level model: a line is a list of MAP_W words; each word needs two
    // fetch cycles, then loads into the single output slot as soon as it is free.
    bit          m_active = 0;
    bit          m_valid  = 0;
    bit          m_ovr    = 0;
    int          m_wait   = 0;
    int          m_k      = 0;
    int          m_row    = 0;
    int          m_fine   = 0;
    int          m_cb     = 0;
    logic [15:0] m_data   = '0;
    int          m_col    = 0;

    always @(posedge clk_i) begin : model
        bit was_active;
        bit load;
        if (rst_ni) begin
            was_active = m_active;
            load = m_active && (m_wait == 0) && (!m_valid || px_ready_i);
            if (load) begin
                m_data  = word_of(m_row, m_fine, m_cb, m_k);
                m_col   = m_k;
                m_valid = 1;
                if (m_k == MAP_W - 1) m_active = 0;
                else begin
                    m_k++;
                    m_wait = 2;
                end
            end else begin
                if (m_valid && px_ready_i) m_valid = 0;
                if (m_active && m_wait > 0) m_wait--;
            end
            m_ovr = line_start_i && was_active;
            if (!was_active && line_start_i) begin
                m_active = 1;
                m_k      = 0;
                m_wait   = 2;
                m_row    = int'(line_i[6:3]);
                m_fine   = int'(line_i[2:0]);
                m_cb     = int'(col_base_i);
            end
        end
    end

    always @(negedge clk_i) begin : compare
        bit exp_load;
        if (!rst_ni) begin
            m_active = 0; m_valid = 0; m_ovr = 0; m_wait = 0; m_k = 0;
            check("rst_busy",    busy_o,      0);
            check("rst_valid",   px_valid_o,  0);
            check("rst_done",    done_o,      0);
            check("rst_overrun", overrun_o,   0);
            check("rst_map",     map_addr_o,  0);
            check("rst_tile",    tile_addr_o, 0);
            check("rst_data",    px_data_o,   0);
            check("rst_col",     px_col_o,    0);
        end else begin
            exp_load = m_active && (m_wait == 0) && (!m_valid || px_ready_i);
            check("busy",    busy_o,     m_active);
            check("valid",   px_valid_o, m_valid);
            check("overrun", overrun_o,  m_ovr);
            check("done",    done_o,     exp_load && (m_k == MAP_W - 1));
            if (m_valid) begin
                check("px_data", px_data_o, m_data);
                check("px_col",  px_col_o,  m_col);
            end
            if (!m_active) begin
                check("idle_map",  map_addr_o,  0);
                check("idle_tile", tile_addr_o, 0);
            end else if (m_wait == 2) begin
                check("map_addr", map_addr_o, map_index(m_row, m_cb, m_k));
            end else begin
                check("tile_addr", tile_addr_o, tile_index(m_row, m_fine, m_cb, m_k));
            end
        end
    end

    task automatic start_line(input int line, input int cb, output int s);
        @(posedge clk_i); #2;
        line_start_i = 1'b1;
        line_i       = 8'(line);
        col_base_i   = 5'(cb);
        s            = cyc;
        @(posedge clk_i); #2;
        line_start_i = 1'b0;
    endtask

    task automatic wait_done(input int s, output int dt);
        dt = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                dt = cyc - s;
                return;
            end
        end
    endtask

    task automatic wait_col(input int col, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i); #2;
            if (px_valid_o && int'(px_col_o) == col) begin
                ok = 1;
                return;
            end
        end
        check("wait_col_timeout", 1, 0);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk_i);
        #2;
    endtask

    initial begin
        int s, dt, ovr0, cb;
        bit ok;
        logic [15:0] held;
        for (int i = 0; i < 1024; i++) map_mem[i]  = 8'($urandom);
        for (int i = 0; i < 2048; i++) tile_mem[i] = 16'($urandom);

        // reset with random inputs
        rst_ni = 1'b0;
        for (int i = 0; i < 6; i++) begin
            line_start_i = 1'($urandom);
            line_i       = 8'($urandom);
            col_base_i   = 5'($urandom);
            px_ready_i   = 1'($urandom);
            #10;
        end
        @(posedge clk_i); #2;
        rst_ni = 1'b1; line_start_i = 1'b0; px_ready_i = 1'b1;
        settle(2);

        // line 19: row 2, fine 3; hand-computed addresses
        map_mem[10'h040] = 8'h05;
        start_line(19, 0, s);
        @(negedge clk_i);
        check("t2_map_addr", map_addr_o, 32'h040);
        @(negedge clk_i);
        check("t2_tile_addr", tile_addr_o, 32'h02B);
        @(negedge clk_i);
        @(negedge clk_i);
        check("t2_first_valid", px_valid_o, 1);
        check("t2_first_data",  px_data_o, tile_mem[11'h02B]);
        check("t2_first_col",   px_col_o,  0);
        wait_done(s, dt);
        check("t2_done_time", dt, 96);
        settle(3);

        // scroll wrap
        start_line(8'h2A, 30, s);
        for (int k = 0; k < MAP_W; k++) begin
            while (cyc < s + 1 + 3 * k) @(negedge clk_i);
            if (k < 4 || k == MAP_W - 1) begin
                check("t3_map_col", map_addr_o[COL_W-1:0], (30 + k) % MAP_W);
            end
        end
        wait_done(s, dt);
        check("t3_done_time", dt, 96);
        settle(3);

        // ready stall while column 5 is pending
        start_line(8'h3C, 7, s);
        wait_col(5, ok);
        px_ready_i = 1'b0;
        held = word_of(7, 4, 7, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("t4_hold_data", px_data_o, held);
            check("t4_hold_col",  px_col_o,  5);
        end
        @(posedge clk_i); #2;
        px_ready_i = 1'b1;
        wait_done(s, dt);
        check("t4_stall_delay_ok", (dt >= 104 && dt <= 106), 1);
        settle(3);

        // overrun at column 12
        start_line(8'h11, 3, s);
        ovr0 = ovr_seen;
        wait_col(12, ok);
        line_start_i = 1'b1; line_i = 8'h7F; col_base_i = 5'd9;
        @(posedge clk_i); #2;
        line_start_i = 1'b0;
        wait_done(s, dt);
        check("t5_done_time", dt, 96);
        check("t5_overrun_count", ovr_seen - ovr0, 1);
        settle(3);

        // async reset mid-line, then line 0
        start_line(8'h55, 12, s);
        wait_col(7, ok);
        rst_ni = 1'b0;
        #1;
        check("t6_valid_now", px_valid_o, 0);
        check("t6_busy_now",  busy_o,     0);
        settle(3);
        rst_ni = 1'b1;
        cb = int'($urandom_range(0, 31));
        start_line(0, cb, s);
        while (cyc < s + 4) @(negedge clk_i);
        check("t6_first_valid", px_valid_o, 1);
        check("t6_first_col",   px_col_o,   0);
        check("t6_first_data",  px_data_o,  word_of(0, 0, cb, 0));
        wait_done(s, dt);
        check("t6_done_time", dt, 96);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i); #2;
            px_ready_i   = ($urandom_range(0, 3) != 0);
            line_start_i = ($urandom_range(0, 39) == 0);
            line_i       = 8'($urandom);
            col_base_i   = 5'($urandom);
        end
        @(posedge clk_i); #2;
        line_start_i = 1'b0;
        px_ready_i   = 1'b1;
        settle(150);
        check("final_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
